// File: rtl/sb_tx_serializer_if.sv
// Sideband message handshake between an initiator and the TX serializer.
// Latency: none (wires only).
// Backpressure: the initiator holds msg_valid_i and its payload until msg_ready_o is seen.
interface sb_tx_serializer_if;
   logic [63:0] msg_i;
   logic [63:0] data_i;
   logic        has_data_i;
   logic        msg_valid_i;
   logic        msg_ready_o;
   logic        sendNextFlag_o;

   modport master (
      output msg_i, data_i, has_data_i, msg_valid_i,
      input  msg_ready_o, sendNextFlag_o
   );

   modport slave (
      input  msg_i, data_i, has_data_i, msg_valid_i,
      output msg_ready_o, sendNextFlag_o
   );
endinterface

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: header (+ optional payload) shifted out LSB first, each word followed by an idle gap.
// Latency: bit 0 of the header is on the pin the cycle after the accept edge; pins are registered.
// Backpressure: msg_ready_o is high only while idle and enabled; sendNextFlag_o pulses when a packet and its gap are done.
module sb_tx_serializer #(
   parameter int UI_CYCLES = 2,
   parameter int PKT_UI    = 64,
   parameter int GAP_UI    = 32
) (
   input  logic               clk_800MHz,
   input  logic               reset_n,
   input  logic               enable_i,
   sb_tx_serializer_if.slave  sb,
   output logic               busy_o,
   output logic               SB_clkPin_TX_o,
   output logic               SB_dataPin_TX_o
);

   localparam int PW = (UI_CYCLES > 1) ? $clog2(UI_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, HDR, GAP1, DATA, GAP2} state_t;

   state_t        state_q, state_d;
   logic [6:0]    ui_q, ui_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [63:0]   sh_q, sh_d;
   logic [63:0]   data_q, data_d;
   logic          hd_q, hd_d;
   logic          flag_q, flag_d;
   logic          clk_pin_d, dat_pin_d;
   logic          ui_end, last_ui, accept, serial_d;

   // Ready is forced low during reset so every output reads 0 while reset_n is low.
   assign sb.msg_ready_o    = reset_n & enable_i & (state_q == IDLE);
   assign sb.sendNextFlag_o = flag_q;
   assign busy_o            = (state_q != IDLE);
   assign accept            = sb.msg_valid_i & sb.msg_ready_o;
   assign ui_end            = (ph_q == PW'(UI_CYCLES - 1));
   assign last_ui           = (state_q == HDR || state_q == DATA) ? (ui_q == 7'(PKT_UI - 1))
                                                                   : (ui_q == 7'(GAP_UI - 1));

   // Next-state, counters, shift register and the pin values for the coming cycle.
   always_comb begin
      state_d = state_q;
      ui_d    = ui_q;
      ph_d    = ph_q;
      sh_d    = sh_q;
      data_d  = data_q;
      hd_d    = hd_q;
      flag_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = HDR;
               ui_d    = 7'd0;
               ph_d    = '0;
               sh_d    = sb.msg_i;
               data_d  = sb.data_i;
               hd_d    = sb.has_data_i;
            end
         end
         default: begin
            ph_d = ui_end ? '0 : ph_q + 1'b1;
            if (ui_end) begin
               ui_d = last_ui ? 7'd0 : ui_q + 7'd1;
               if (state_q == HDR || state_q == DATA) sh_d = sh_q >> 1;
               if (last_ui) begin
                  case (state_q)
                     HDR:  state_d = GAP1;
                     GAP1: begin
                        if (hd_q) begin
                           state_d = DATA;
                           sh_d    = data_q;
                        end else begin
                           state_d = IDLE;
                           flag_d  = 1'b1;
                        end
                     end
                     DATA: state_d = GAP2;
                     GAP2: begin
                        state_d = IDLE;
                        flag_d  = 1'b1;
                     end
                     default: state_d = IDLE;
                  endcase
               end
            end
            // Losing enable mid-packet drops it silently: no completion flag.
            if (!enable_i) begin
               state_d = IDLE;
               ui_d    = 7'd0;
               ph_d    = '0;
               flag_d  = 1'b0;
            end
         end
      endcase
      serial_d  = (state_d == HDR) || (state_d == DATA);
      dat_pin_d = serial_d & sh_d[0];
      clk_pin_d = serial_d && (ph_d >= PW'(UI_CYCLES / 2));
   end

   // State, counters, shift registers and registered pins.
   always_ff @(posedge clk_800MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         ui_q            <= 7'd0;
         ph_q            <= '0;
         sh_q            <= 64'd0;
         data_q          <= 64'd0;
         hd_q            <= 1'b0;
         flag_q          <= 1'b0;
         SB_clkPin_TX_o  <= 1'b0;
         SB_dataPin_TX_o <= 1'b0;
      end else begin
         state_q         <= state_d;
         ui_q            <= ui_d;
         ph_q            <= ph_d;
         sh_q            <= sh_d;
         data_q          <= data_d;
         hd_q            <= hd_d;
         flag_q          <= flag_d;
         SB_clkPin_TX_o  <= clk_pin_d;
         SB_dataPin_TX_o <= dat_pin_d;
      end
   end

endmodule
